// File: rtl/tetris_pkg.sv
// tetris_pkg: shared command codes, source indices and gravity helpers for the Tetris controller.
// Provides command code constants, source indices in arbitration priority order
// (lowest index wins), the level width, the output slot state type and the
// gravity period calculation.
package tetris_pkg;
    localparam int LEVEL_W   = 4;
    localparam int NUM_SRC   = 5;
    localparam int SRC_UP    = 0;
    localparam int SRC_LEFT  = 1;
    localparam int SRC_RIGHT = 2;
    localparam int SRC_DOWN  = 3;
    localparam int SRC_GRAV  = 4;
    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_GRAV  = 3'b001;
    localparam logic [2:0] CMD_DOWN  = 3'b011;
    localparam logic [2:0] CMD_LEFT  = 3'b101;
    localparam logic [2:0] CMD_RIGHT = 3'b110;
    localparam logic [2:0] CMD_ROT   = 3'b111;
    typedef enum logic {EMPTY, FULL} slot_t;
    function automatic logic [2:0] cmd_of(input logic [2:0] src);
        return src == 3'(SRC_UP)    ? CMD_ROT :
               src == 3'(SRC_LEFT)  ? CMD_LEFT :
               src == 3'(SRC_RIGHT) ? CMD_RIGHT :
               src == 3'(SRC_DOWN)  ? CMD_DOWN : CMD_GRAV;
    endfunction
    // max(base - lvl*step, floor_p) without wrapping below zero
    function automatic logic [31:0] gravity_period(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [31:0] base,
                                                   input logic [31:0] step,
                                                   input logic [31:0] floor_p);
        logic [31:0] drop;
        drop = 32'(lvl) * step;
        return (base > drop && base - drop > floor_p) ? base - drop : floor_p;
    endfunction
endpackage

// File: rtl/repeat_timer.sv
// repeat_timer: key edge detector with delayed auto-repeat.
// Ports: clk, rst (async, active-high); key = key level; hold = force idle (game over);
// req = one-cycle request on the press edge, DAS_CYCLES after the press, then every ARR_CYCLES.
module repeat_timer #(
    parameter int DAS_CYCLES = 20_000_000,
    parameter int ARR_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic hold,
    output logic req
);
    logic        prev, rep;
    logic [31:0] cnt, target;
    assign target = rep ? 32'(ARR_CYCLES) : 32'(DAS_CYCLES);
    assign req    = ~hold & key & (~prev | (cnt == target));
    // cnt holds cycles since the press (or since the last repeat); rep selects the ARR interval
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
            rep  <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= key;
            if (hold || !key) begin
                cnt <= '0;
                rep <= 1'b0;
            end else begin
                cnt <= (!prev || cnt == target) ? 32'd1 : cnt + 32'd1;
                rep <= prev && (rep || cnt == target);
            end
        end
    end
endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: merges key requests and the gravity tick into one valid/ready command stream.
// Ports: clk, rst (async, active-high); left/right/down/up = key levels; score = current score;
// fail = game over; cmd_ready = engine accepts; cmd_valid/cmd = offered command; level = gravity level.
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int GRAVITY_BASE = 50_000_000,
    parameter int GRAVITY_STEP = 3_000_000,
    parameter int GRAVITY_MIN  = 5_000_000,
    parameter int DAS_CYCLES   = 20_000_000,
    parameter int ARR_CYCLES   = 5_000_000,
    parameter int AGE_LIMIT    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               left,
    input  logic               right,
    input  logic               down,
    input  logic               up,
    input  logic [6:0]         score,
    input  logic               fail,
    input  logic               cmd_ready,
    output logic               cmd_valid,
    output logic [2:0]         cmd,
    output logic [LEVEL_W-1:0] level
);
    logic [NUM_SRC-1:0] req, pend, take;
    logic [31:0]        gcnt, period;
    logic [2:0]         age, win;
    logic               up_prev, load;
    slot_t              state;

    repeat_timer #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_left (
        .clk(clk), .rst(rst), .key(left), .hold(fail), .req(req[SRC_LEFT]));
    repeat_timer #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_right (
        .clk(clk), .rst(rst), .key(right), .hold(fail), .req(req[SRC_RIGHT]));
    repeat_timer #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_down (
        .clk(clk), .rst(rst), .key(down), .hold(fail), .req(req[SRC_DOWN]));

    assign req[SRC_UP]   = ~fail & up & ~up_prev;
    assign req[SRC_GRAV] = ~fail & (gcnt == period - 32'd1);

    // lowest pending index wins, unless gravity has waited through AGE_LIMIT key grants
    always_comb begin
        win = 3'(SRC_GRAV);
        for (int i = NUM_SRC - 1; i >= 0; i--) if (pend[i]) win = 3'(i);
        if (pend[SRC_GRAV] && 32'(age) >= 32'(AGE_LIMIT)) win = 3'(SRC_GRAV);
    end

    // a load happens into an empty slot or on the same edge the current command transfers
    assign load = ~fail & (|pend) & (state == EMPTY || cmd_ready);
    assign take = load ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << win) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            up_prev   <= 1'b0;
            gcnt      <= '0;
            period    <= gravity_period('0, 32'(GRAVITY_BASE), 32'(GRAVITY_STEP), 32'(GRAVITY_MIN));
            level     <= '0;
            age       <= '0;
            state     <= EMPTY;
            cmd_valid <= 1'b0;
            cmd       <= CMD_IDLE;
        end else begin
            up_prev <= up;
            level   <= LEVEL_W'(score >> 3);
            // new requests are OR-ed in after the grant clear, so a same-edge re-request survives
            pend    <= fail ? '0 : (pend & ~take) | req;
            if (fail) begin
                gcnt <= '0;
            end else if (req[SRC_GRAV]) begin
                gcnt   <= '0;
                period <= gravity_period(level, 32'(GRAVITY_BASE), 32'(GRAVITY_STEP), 32'(GRAVITY_MIN));
            end else begin
                gcnt <= gcnt + 32'd1;
            end
            if (load) age <= (win == 3'(SRC_GRAV)) ? 3'd0 : age + {2'b00, pend[SRC_GRAV]};
            if (load) begin
                state     <= FULL;
                cmd_valid <= 1'b1;
                cmd       <= cmd_of(win);
            end else if (state == FULL && cmd_ready) begin
                state     <= EMPTY;
                cmd_valid <= 1'b0;
                cmd       <= CMD_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: self-checking bench for move_scheduler with scaled timing parameters.
module tb_move_scheduler;
    logic       clk = 1'b0;
    logic       rst, left, right, down, up, fail, cmd_ready;
    logic [6:0] score;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [3:0] level;
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       l, r, u, rdy, ev;
        logic [2:0] ec;
    } vec_t;
    vec_t tbl[15];

    always #5 clk = ~clk;

    move_scheduler #(
        .GRAVITY_BASE(200), .GRAVITY_STEP(12), .GRAVITY_MIN(30),
        .DAS_CYCLES(20), .ARR_CYCLES(5), .AGE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .down(down), .up(up),
        .score(score), .fail(fail), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd(cmd), .level(level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic l, r, u, rdy, ev, input logic [2:0] ec);
        vec_t v;
        v.l = l; v.r = r; v.u = u; v.rdy = rdy; v.ev = ev; v.ec = ec;
        return v;
    endfunction

    task automatic idle_inputs();
        left = 0; right = 0; down = 0; up = 0; fail = 0; cmd_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int n, first, others, rot, gi;
        logic [2:0] c;
        int offs[$];
        int gpos[$];
        int exp_down[4] = '{2, 22, 27, 32};
        int lv_score[5] = '{0, 7, 8, 100, 127};
        int lv_exp[5]   = '{0, 0, 1, 12, 15};

        rst = 1; score = 7'd127;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset_valid", cmd_valid, 0);
        check("reset_cmd", cmd, 0);
        check("reset_level", level, 0);

        // simultaneous left/right/up edges with a second left press while pending
        tbl[0] = mk(1, 1, 1, 0, 0, 3'b000);
        tbl[1] = mk(0, 0, 0, 0, 0, 3'b000);
        for (int i = 2; i <= 9; i++) tbl[i] = mk(i == 4, 0, 0, 0, 1, 3'b111);
        tbl[10] = mk(0, 0, 0, 1, 1, 3'b111);
        tbl[11] = mk(0, 0, 0, 1, 1, 3'b101);
        tbl[12] = mk(0, 0, 0, 1, 1, 3'b110);
        tbl[13] = mk(0, 0, 0, 1, 0, 3'b000);
        tbl[14] = mk(0, 0, 0, 1, 0, 3'b000);
        score = 0;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("tbl_valid[%0d]", i), cmd_valid, tbl[i].ev);
            check($sformatf("tbl_cmd[%0d]", i), cmd, tbl[i].ec);
            left = tbl[i].l; right = tbl[i].r; up = tbl[i].u; cmd_ready = tbl[i].rdy;
        end

        // level mapping
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            score = 7'(lv_score[i]);
            @(negedge clk);
            check($sformatf("level_score%0d", lv_score[i]), level, lv_exp[i]);
        end

        // single left pulse, ready always high, nothing else before gravity
        score = 0;
        do_reset();
        cmd_ready = 1; n = 0; first = -1; c = 0;
        for (int i = 0; i < 196; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                n++;
                if (first < 0) begin first = i; c = cmd; end
            end
            left = (i == 0);
        end
        check("left_count", n, 1);
        check("left_offset", first, 2);
        check("left_cmd", c, 3'b101);

        // down held for DAS + 3*ARR cycles
        do_reset();
        cmd_ready = 1; others = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd == 3'b011) offs.push_back(i);
            else if (cmd_valid) others++;
            down = (i < 35);
        end
        check("down_count", offs.size(), 4);
        check("down_others", others, 0);
        for (int k = 0; k < 4; k++)
            if (k < offs.size()) check($sformatf("down_offset[%0d]", k), offs[k], exp_down[k]);

        // gravity at level 15: first period is the reset period, then the floor
        score = 127;
        do_reset();
        cmd_ready = 1; others = 0;
        for (int i = 0; i < 276; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd == 3'b001) gpos.push_back(i);
            else if (cmd_valid) others++;
        end
        check("grav_level", level, 15);
        check("grav_count", gpos.size(), 3);
        check("grav_others", others, 0);
        if (gpos.size() == 3) begin
            check("grav_first", gpos[0], 200);
            check("grav_gap1", gpos[1] - gpos[0], 30);
            check("grav_gap2", gpos[2] - gpos[1], 30);
        end

        // gravity anti-starvation against a rotate re-pending every 3 cycles
        score = 0;
        do_reset();
        rot = 0; gi = -1;
        for (int i = 0; i < 270; i++) begin
            @(negedge clk);
            up = (i % 3 == 0);
            cmd_ready = (i >= 210) && (i % 3 == 2);
            if (cmd_valid && cmd_ready && gi < 0) begin
                if (cmd == 3'b111) rot++;
                if (cmd == 3'b001) gi = i;
            end
        end
        check("age_rotates", rot, 5);
        check("age_grav_at", gi, 227);

        // fail while a command is held, then nothing more
        do_reset();
        n = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (i >= 3 && i <= 8) begin
                check($sformatf("fail_hold_valid[%0d]", i), cmd_valid, 1);
                check($sformatf("fail_hold_cmd[%0d]", i), cmd, 3'b101);
            end
            if (i >= 9) n += int'(cmd_valid);
            left = (i == 0); fail = (i >= 2); right = (i == 4); up = (i == 12);
            cmd_ready = (i == 8);
        end
        check("fail_idle", n, 0);
        fail = 0; cmd_ready = 1; n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n += int'(cmd_valid);
        end
        check("post_fail_idle", n, 0);

        // asynchronous reset while a command is offered
        cmd_ready = 0;
        @(negedge clk); up = 1;
        @(negedge clk); up = 0;
        @(negedge clk);
        check("pre_rst_valid", cmd_valid, 1);
        check("pre_rst_cmd", cmd, 3'b111);
        #2 rst = 1;
        #1;
        check("async_rst_valid", cmd_valid, 0);
        check("async_rst_cmd", cmd, 0);
        @(negedge clk); rst = 0; cmd_ready = 1; n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n += int'(cmd_valid);
        end
        check("post_rst_idle", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
